// File: rtl/cdb_broadcaster_pkg.sv
// Shared CDB types and sizing: packet layout reused by RS lines, ROB and PRF write port.
package cdb_broadcaster_pkg;

  localparam int WAYS    = 3;
  localparam int NUM_FU  = 5;
  localparam int REG_LEN = 64;
  localparam int PRF     = 64;
  localparam int ROB     = 16;

  localparam int PRF_W = $clog2(PRF);
  localparam int ROB_W = $clog2(ROB);
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic [REG_LEN-1:0] data;
    logic [PRF_W-1:0]   PRF_idx;
    logic [ROB_W-1:0]   rob_idx;
  } cdb_packet_t;

  function automatic cdb_packet_t pack_result(
    input logic [REG_LEN-1:0] data,
    input logic [PRF_W-1:0]   prf_idx,
    input logic [ROB_W-1:0]   rob_idx
  );
    cdb_packet_t p;
    p.data    = data;
    p.PRF_idx = prf_idx;
    p.rob_idx = rob_idx;
    return p;
  endfunction

endpackage

// File: rtl/cdb_broadcaster_if.sv
// FU result inputs with per-FU ready, plus the WAYS-lane CDB broadcast outputs.
interface cdb_broadcaster_if;
  import cdb_broadcaster_pkg::*;

  logic [NUM_FU-1:0]              fu_valid;
  logic [NUM_FU-1:0][REG_LEN-1:0] fu_data;
  logic [NUM_FU-1:0][PRF_W-1:0]   fu_PRF_idx;
  logic [NUM_FU-1:0][ROB_W-1:0]   fu_rob_idx;
  logic [NUM_FU-1:0]              fu_ready;

  logic [WAYS-1:0][REG_LEN-1:0]   CDB_Data;
  logic [WAYS-1:0][PRF_W-1:0]     CDB_PRF_idx;
  logic [WAYS-1:0][ROB_W-1:0]     CDB_ROB_idx;
  logic [WAYS-1:0]                CDB_valid;

  // master: FU side / CDB receivers; slave: the broadcaster itself
  modport master (
    output fu_valid, fu_data, fu_PRF_idx, fu_rob_idx,
    input  fu_ready, CDB_Data, CDB_PRF_idx, CDB_ROB_idx, CDB_valid
  );

  modport slave (
    input  fu_valid, fu_data, fu_PRF_idx, fu_rob_idx,
    output fu_ready, CDB_Data, CDB_PRF_idx, CDB_ROB_idx, CDB_valid
  );

endinterface

// File: rtl/cdb_broadcaster_rr_multi_select.sv
// Combinational round-robin picker: grants up to K of N requests starting at ptr,
// assigning them to lanes 0..K-1 in scan order, and returns the pointer past the last grant.
module rr_multi_select #(
  parameter int N = 5,
  parameter int K = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1,
  localparam int LW = $clog2(K + 1),
  localparam int SW = (K > 1) ? $clog2(K) : 1
) (
  input  logic [N-1:0]        req,
  input  logic [PW-1:0]       ptr,
  output logic [N-1:0]        grant,
  output logic [K-1:0][N-1:0] sel,
  output logic [PW-1:0]       next_ptr
);

  logic [PW-1:0] idx;
  logic [LW-1:0] lanes;

  always_comb begin
    grant    = '0;
    sel      = '0;
    next_ptr = ptr;
    idx      = ptr;
    lanes    = '0;
    for (int s = 0; s < N; s++) begin
      if (req[idx] && (lanes < LW'(K))) begin
        grant[idx]              = 1'b1;
        sel[lanes[SW-1:0]][idx] = 1'b1;
        lanes                   = lanes + 1'b1;
        next_ptr                = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
      end
      idx = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmit end: one holding slot per FU, round-robin onto WAYS registered lanes.
// Accept-to-broadcast latency 2 cycles; fu_ready stays high while a slot is free or draining.
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             squash,
  cdb_broadcaster_if.slave bus
);

  logic [NUM_FU-1:0]             held;
  logic [NUM_FU-1:0]             grant;
  logic [NUM_FU-1:0]             take;
  cdb_packet_t [NUM_FU-1:0]      slot;
  logic [PTR_W-1:0]              ptr;
  logic [PTR_W-1:0]              next_ptr;
  logic [WAYS-1:0][NUM_FU-1:0]   sel;
  cdb_packet_t [WAYS-1:0]        lane_pkt;
  logic [WAYS-1:0]               lane_vld;
  cdb_packet_t [WAYS-1:0]        cdb_q;
  logic [WAYS-1:0]               cdb_vld_q;

  rr_multi_select #(
    .N (NUM_FU),
    .K (WAYS)
  ) u_select (
    .req      (held),
    .ptr      (ptr),
    .grant    (grant),
    .sel      (sel),
    .next_ptr (next_ptr)
  );

  // A slot being granted this cycle can be refilled in the same cycle.
  assign bus.fu_ready = {NUM_FU{reset & ~squash}} & (~held | grant);
  assign take         = bus.fu_valid & bus.fu_ready;

  always_comb begin
    lane_pkt = '0;
    lane_vld = '0;
    for (int w = 0; w < WAYS; w++) begin
      lane_vld[w] = |sel[w];
      for (int i = 0; i < NUM_FU; i++) begin
        if (sel[w][i]) lane_pkt[w] = slot[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      held      <= '0;
      slot      <= '0;
      ptr       <= '0;
      cdb_q     <= '0;
      cdb_vld_q <= '0;
    end else begin
      if (squash) begin
        held      <= '0;
        cdb_q     <= '0;
        cdb_vld_q <= '0;
      end else begin
        held      <= take | (held & ~grant);
        cdb_q     <= lane_pkt;
        cdb_vld_q <= lane_vld;
        if (|grant) ptr <= next_ptr;
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (take[i]) slot[i] <= pack_result(bus.fu_data[i], bus.fu_PRF_idx[i], bus.fu_rob_idx[i]);
      end
    end
  end

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      bus.CDB_Data[w]    = cdb_q[w].data;
      bus.CDB_PRF_idx[w] = cdb_q[w].PRF_idx;
      bus.CDB_ROB_idx[w] = cdb_q[w].rob_idx;
    end
    bus.CDB_valid = cdb_vld_q;
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Scoreboard bench for cdb_broadcaster: driver runs a reference model and queues expected lanes,
// a negedge monitor pops and compares every CDB lane.
module tb_cdb_broadcaster;
  import cdb_broadcaster_pkg::*;

  typedef struct {
    int          cyc;
    int          lane;
    cdb_packet_t pkt;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic squash = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t              exp_q[$];
  exp_t              mon_e;
  cdb_packet_t       mon_got;
  bit [NUM_FU-1:0]   m_held;
  cdb_packet_t       m_pkt[NUM_FU];
  int                m_ptr;
  cdb_packet_t       stg[NUM_FU];

  cdb_broadcaster_if bus();

  cdb_broadcaster dut (
    .clock  (clock),
    .reset  (reset),
    .squash (squash),
    .bus    (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic rand_payload();
    for (int i = 0; i < NUM_FU; i++) begin
      stg[i].data    = {$urandom, $urandom};
      stg[i].PRF_idx = PRF_W'($urandom);
      stg[i].rob_idx = ROB_W'($urandom);
    end
  endtask

  task automatic model_reset();
    m_held = '0;
    m_ptr  = 0;
    exp_q.delete();
  endtask

  // One clock cycle of stimulus; the model decides readiness and what hits the CDB next cycle.
  task automatic step(input logic [NUM_FU-1:0] v, input logic sq);
    int              order[$];
    bit [NUM_FU-1:0] granted;
    logic [NUM_FU-1:0] exp_rdy;
    exp_t            e;
    @(posedge clock);
    #1;
    bus.fu_valid = v;
    squash       = sq;
    for (int i = 0; i < NUM_FU; i++) begin
      bus.fu_data[i]    = stg[i].data;
      bus.fu_PRF_idx[i] = stg[i].PRF_idx;
      bus.fu_rob_idx[i] = stg[i].rob_idx;
    end
    granted = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      int i;
      i = (m_ptr + k) % NUM_FU;
      if (m_held[i] && order.size() < WAYS) begin
        order.push_back(i);
        granted[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_FU; i++)
      exp_rdy[i] = reset && !sq && (!m_held[i] || granted[i]);
    if (!sq) begin
      for (int l = 0; l < order.size(); l++) begin
        e.cyc  = cyc + 1;
        e.lane = l;
        e.pkt  = m_pkt[order[l]];
        exp_q.push_back(e);
      end
      if (order.size() > 0) m_ptr = (order[order.size()-1] + 1) % NUM_FU;
    end
    for (int i = 0; i < NUM_FU; i++) begin
      if (sq) m_held[i] = 1'b0;
      else if (v[i] && exp_rdy[i]) begin
        m_held[i] = 1'b1;
        m_pkt[i]  = stg[i];
      end else if (granted[i]) m_held[i] = 1'b0;
    end
    @(negedge clock);
    checks++;
    if (bus.fu_ready !== exp_rdy) begin
      errors++;
      $display("FAIL fu_ready cyc=%0d got=%b exp=%b", cyc, bus.fu_ready, exp_rdy);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b0);
  endtask

  always @(negedge clock) begin
    for (int w = 0; w < WAYS; w++) begin
      mon_got.data    = bus.CDB_Data[w];
      mon_got.PRF_idx = bus.CDB_PRF_idx[w];
      mon_got.rob_idx = bus.CDB_ROB_idx[w];
      checks++;
      if (bus.CDB_valid[w]) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL cdb_unexpected cyc=%0d lane=%0d got=%h exp=none", cyc, w, mon_got);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.lane != w || mon_e.pkt != mon_got) begin
            errors++;
            $display("FAIL cdb_lane cyc=%0d lane=%0d got=%h exp cyc=%0d lane=%0d pkt=%h",
                     cyc, w, mon_got, mon_e.cyc, mon_e.lane, mon_e.pkt);
          end
        end
      end else if (mon_got != '0) begin
        errors++;
        $display("FAIL cdb_idle_lane cyc=%0d lane=%0d got=%h exp=0", cyc, w, mon_got);
      end
    end
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL cdb_missed cyc=%0d lane=%0d got=none exp=%h", mon_e.cyc, mon_e.lane, mon_e.pkt);
    end
  end

  initial begin
    bus.fu_valid   = '0;
    bus.fu_data    = '0;
    bus.fu_PRF_idx = '0;
    bus.fu_rob_idx = '0;
    for (int i = 0; i < NUM_FU; i++) stg[i] = '0;
    model_reset();

    #12;
    checks++;
    if (bus.CDB_valid !== '0 || bus.fu_ready !== '0) begin
      errors++;
      $display("FAIL reset_state got valid=%b ready=%b exp valid=0 ready=0", bus.CDB_valid, bus.fu_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.fu_ready !== '1) begin
      errors++;
      $display("FAIL ready_after_reset got=%b exp=%b", bus.fu_ready, {NUM_FU{1'b1}});
    end

    // single FU, fixed payload
    stg[0] = pack_result(64'habc, 6'h11, 4'h3);
    step(5'b00001, 1'b0);
    idle(4);

    // all FUs once, then continuously
    rand_payload();
    step(5'b11111, 1'b0);
    idle(4);
    for (int k = 0; k < 10; k++) begin
      rand_payload();
      step(5'b11111, 1'b0);
    end
    idle(4);

    // FU1 streaming with incrementing payload
    for (int k = 0; k < 20; k++) begin
      stg[1] = pack_result(64'h1000 + 64'(k), PRF_W'(k), ROB_W'(k));
      step(5'b00010, 1'b0);
    end
    idle(3);

    // squash with four held slots, then normal traffic
    rand_payload();
    step(5'b01111, 1'b0);
    step('0, 1'b1);
    idle(3);
    rand_payload();
    step(5'b00110, 1'b0);
    idle(3);

    // reset mid-operation discards held and in-flight results
    rand_payload();
    step(5'b01111, 1'b0);
    step('0, 1'b0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.CDB_valid !== '0 || bus.fu_ready !== '0) begin
      errors++;
      $display("FAIL reset_midop got valid=%b ready=%b exp valid=0 ready=0", bus.CDB_valid, bus.fu_ready);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2;
    reset = 1'b1;
    idle(4);

    // randomized traffic with occasional squash
    for (int k = 0; k < 300; k++) begin
      rand_payload();
      step(NUM_FU'($urandom), ($urandom_range(15) == 0));
    end
    idle(4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
